// File: rtl/nd_nto1.sv
// N-to-1 merge node: NCH four-phase input channels arbitrated into one shared
// FIFO, drained onto a single four-phase output channel.
`ifndef NS_2to1_FSZ
`define NS_2to1_FSZ 2
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_nto1_lane (
  input  logic i_clk,
  input  logic reset,
  input  logic ready,
  input  logic req,
  input  logic wr_sel,
  output logic ack
);
  // ack rises on the write edge, falls once the sender has released req
  always_ff @(posedge i_clk or posedge reset)
    if (reset)         ack <= 1'b0;
    else if (ready) begin
      if (wr_sel)      ack <= 1'b1;
      else if (!req)   ack <= 1'b0;
    end
endmodule

module nd_nto1 #(
  parameter int NCH  = 4,
  parameter int FSZ  = `NS_2to1_FSZ,
  parameter int ASZ  = `NS_ADDRESS_SIZE,
  parameter int DSZ  = `NS_DATA_SIZE,
  parameter int RSZ  = `NS_REDUN_SIZE,
  parameter int MODE = 0
) (
  input  logic                           i_clk,
  input  logic                           reset,
  output logic                           ready,
  input  logic [NCH*(2*ASZ+DSZ+RSZ)-1:0] rcv_msg,
  input  logic [NCH-1:0]                 rcv_req,
  output logic [NCH-1:0]                 rcv_ack,
  output logic [2*ASZ+DSZ+RSZ-1:0]       snd_msg,
  output logic                           snd_req,
  input  logic                           snd_ack,
  output logic [FSZ:0]                   fifo_cnt
);
  localparam int MSZ   = 2*ASZ + DSZ + RSZ;
  localparam int DEPTH = 1 << FSZ;
  localparam int PSZ   = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0][MSZ-1:0] msgs;
  logic [NCH-1:0]          elig;
  logic [PSZ-1:0]          ptr, gnt;
  logic [FSZ-1:0]          head, tail;
  logic                    any, full, wr, pop, busy;
  logic [MSZ-1:0]          mem [DEPTH];

  assign msgs = rcv_msg;
  assign elig = rcv_req & ~rcv_ack;
  assign full = (fifo_cnt == (FSZ+1)'(DEPTH));
  assign wr   = ready & any & ~full;
  // Full is judged on the registered count, so a same-edge pop never frees a slot
  assign pop  = ready & ~busy & ~snd_req & ~snd_ack & (fifo_cnt != '0);

  // Search from ptr (round-robin) or from 0 (fixed priority)
  always_comb begin
    logic [PSZ:0] s;
    gnt = '0;
    any = 1'b0;
    s   = '0;
    for (int k = 0; k < NCH; k++) begin
      s = (MODE == 0) ? ({1'b0, ptr} + (PSZ+1)'(k)) : (PSZ+1)'(k);
      if (s >= (PSZ+1)'(NCH)) s = s - (PSZ+1)'(NCH);
      if (!any && elig[s[PSZ-1:0]]) begin
        any = 1'b1;
        gnt = s[PSZ-1:0];
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    nd_nto1_lane u_lane (
      .i_clk  (i_clk),
      .reset  (reset),
      .ready  (ready),
      .req    (rcv_req[i]),
      .wr_sel (wr && (gnt == PSZ'(i))),
      .ack    (rcv_ack[i])
    );
  end

  always_ff @(posedge i_clk)
    if (wr) mem[tail] <= msgs[gnt];

  always_ff @(posedge i_clk or posedge reset)
    if (reset) begin
      ready    <= 1'b0;
      head     <= '0;
      tail     <= '0;
      fifo_cnt <= '0;
      ptr      <= '0;
      busy     <= 1'b0;
      snd_req  <= 1'b0;
      snd_msg  <= '0;
    end else begin
      ready    <= 1'b1;
      fifo_cnt <= fifo_cnt + (FSZ+1)'(wr) - (FSZ+1)'(pop);
      if (wr)  tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      if (wr && MODE == 0)
        ptr <= (gnt == PSZ'(NCH-1)) ? '0 : gnt + 1'b1;
      // busy keeps snd_msg frozen until the receiver has dropped ack
      if (pop) begin
        snd_msg <= mem[head];
        snd_req <= 1'b1;
        busy    <= 1'b1;
      end else begin
        if (snd_req && snd_ack)            snd_req <= 1'b0;
        if (busy && !snd_req && !snd_ack)  busy    <= 1'b0;
      end
    end
endmodule

// File: tb/tb_nd_nto1.sv
// Directed bench for nd_nto1: vector table for single messages, hand-written
// sequences for arbitration, backpressure, wrap and mid-handshake reset.
module tb_nd_nto1;
  localparam int NCH = 4, FSZ = 2, ASZ = 4, DSZ = 8, RSZ = 4;
  localparam int MSZ = 2*ASZ + DSZ + RSZ;
  typedef logic [MSZ-1:0] msg_t;

  typedef struct {
    int         ch;
    logic [3:0] src, dst;
    logic [7:0] dat;
    logic [3:0] red;
    msg_t       exp;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic rdy0, rdy1;
  logic [NCH-1:0][MSZ-1:0] rmsg0 = '0, rmsg1 = '0;
  logic [NCH-1:0] rreq0 = '0, rreq1 = '0, rack0, rack1;
  msg_t smsg0, smsg1;
  logic sreq0, sreq1, sack0 = 1'b0, sack1 = 1'b0;
  logic [FSZ:0] cnt0, cnt1;

  int checks = 0, failures = 0;
  bit resp_en0 = 1'b0, run1 = 1'b0;
  logic [NCH-1:0] hold0 = '0;
  msg_t rx0[$], rx1[$];
  int n3 = 0;

  nd_nto1 #(.NCH(NCH), .FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .MODE(0)) dut0 (
    .i_clk(clk), .reset(rst), .ready(rdy0), .rcv_msg(rmsg0), .rcv_req(rreq0),
    .rcv_ack(rack0), .snd_msg(smsg0), .snd_req(sreq0), .snd_ack(sack0), .fifo_cnt(cnt0));

  nd_nto1 #(.NCH(NCH), .FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .MODE(1)) dut1 (
    .i_clk(clk), .reset(rst), .ready(rdy1), .rcv_msg(rmsg1), .rcv_req(rreq1),
    .rcv_ack(rack1), .snd_msg(smsg1), .snd_req(sreq1), .snd_ack(sack1), .fifo_cnt(cnt1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic msg_t mk(input int ch, input int seq);
    return {4'(ch), 4'h0, 8'(seq), 4'h0};
  endfunction

  task automatic nwait(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send0(input int ch, input msg_t m);
    int n = 0;
    while ((rreq0[ch] || rack0[ch]) && n < 60) begin nwait(1); n++; end
    if (n >= 60) chk("send_timeout", 32'(n), 0);
    rmsg0[ch] = m;
    rreq0[ch] = 1'b1;
  endtask

  task automatic wait_rx0(input int n);
    int t = 0;
    while (rx0.size() < n && t < 400) begin nwait(1); t++; end
    chk("rx0_count", 32'(rx0.size()), 32'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rreq0 = '0; sack0 = 1'b0; hold0 = '0; resp_en0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx0.delete();
    #1;
  endtask

  // dut0 senders drop req once acked (unless held)
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NCH; i++)
      if (rreq0[i] && rack0[i] && !hold0[i]) rreq0[i] = 1'b0;
  end

  // dut0 four-phase receiver
  initial forever begin
    @(negedge clk);
    if (resp_en0) begin
      if (sreq0 && !sack0) begin rx0.push_back(smsg0); sack0 = 1'b1; end
      else if (!sreq0 && sack0) sack0 = 1'b0;
    end
  end

  // dut1 four-phase receiver
  initial forever begin
    @(negedge clk);
    if (sreq1 && !sack1) begin rx1.push_back(smsg1); sack1 = 1'b1; end
    else if (!sreq1 && sack1) sack1 = 1'b0;
  end

  // dut1: ch1 and ch3 request continuously; priority checked every edge
  initial begin
    int sent[NCH];
    int ch;
    logic pe1, pa3;
    logic [FSZ:0] pc;
    for (int i = 0; i < NCH; i++) sent[i] = 0;
    pe1 = 1'b0; pa3 = 1'b0; pc = '0;
    forever begin
      @(negedge clk);
      if (run1) begin
        if (rack1[3] && !pa3) begin
          n3++;
          chk("m1_ch3_granted_while_ch1_eligible", 32'(pe1), 0);
        end
        if (pe1 && pc < 3'(4) && rdy1) chk("m1_ch1_wins", 32'(rack1[1]), 1);
        for (int q = 0; q < 2; q++) begin
          ch = (q == 0) ? 1 : 3;
          if (rreq1[ch] && rack1[ch]) rreq1[ch] = 1'b0;
          else if (!rreq1[ch] && !rack1[ch] && sent[ch] < 6) begin
            rmsg1[ch] = mk(ch, sent[ch]);
            rreq1[ch] = 1'b1;
            sent[ch]++;
          end
        end
        pe1 = rreq1[1] & ~rack1[1];
        pa3 = rack1[3];
        pc  = cnt1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    int   ord[9];
    msg_t bp[6];
    int   nx1, nx3, t;

    vt[0] = '{ch: 2, src: 4'h1, dst: 4'h5, dat: 8'hA5, red: 4'h0, exp: 20'h15A50};
    vt[1] = '{ch: 0, src: 4'hF, dst: 4'h0, dat: 8'h3C, red: 4'h9, exp: 20'hF03C9};
    vt[2] = '{ch: 3, src: 4'h2, dst: 4'hA, dat: 8'hFF, red: 4'h1, exp: 20'h2AFF1};
    vt[3] = '{ch: 1, src: 4'h7, dst: 4'h3, dat: 8'h00, red: 4'hE, exp: 20'h7300E};
    ord = '{0, 1, 2, 3, 1, 2, 3, 0, 1};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(rdy0), 0);
    chk("rst_ack", 32'(rack0), 0);
    chk("rst_sreq", 32'(sreq0), 0);
    chk("rst_smsg", 32'(smsg0), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    rst = 1'b0;
    #1 chk("ready_before_edge", 32'(rdy0), 0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(rdy0), 1);

    // single messages from the vector table
    resp_en0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nwait(8);
      send0(vt[k].ch, {vt[k].src, vt[k].dst, vt[k].dat, vt[k].red});
      @(posedge clk); #1;
      chk("single_ack", 32'(rack0[vt[k].ch]), 1);
      chk("single_cnt1", 32'(cnt0), 1);
      chk("single_sreq_lo", 32'(sreq0), 0);
      @(posedge clk); #1;
      chk("single_sreq_hi", 32'(sreq0), 1);
      chk("single_smsg", 32'(smsg0), 32'(vt[k].exp));
      chk("single_cnt0", 32'(cnt0), 0);
      wait_rx0(k + 1);
      if (rx0.size() > k) chk("single_rx", 32'(rx0[k]), 32'(vt[k].exp));
    end

    // round-robin bursts
    do_reset();
    resp_en0 = 1'b1;
    for (int i = 0; i < NCH; i++) send0(i, mk(i, i));
    wait_rx0(4);
    send0(1, mk(1, 4));
    wait_rx0(5);
    nwait(4);
    for (int i = 0; i < NCH; i++) send0(i, mk(i, 5 + i));
    wait_rx0(9);
    for (int i = 0; i < 9; i++)
      if (rx0.size() > i) chk("rr_order", 32'(rx0[i][MSZ-1 -: 4]), 32'(ord[i]));

    // backpressure: snd_ack held low
    do_reset();
    for (int i = 0; i < 6; i++) bp[i] = mk(i % 4, i);
    for (int i = 0; i < 6; i++) send0(i % 4, bp[i]);
    nwait(10);
    chk("bp_cnt_full", 32'(cnt0), 4);
    chk("bp_ack1_stalled", 32'(rack0[1]), 0);
    chk("bp_req1_held", 32'(rreq0[1]), 1);
    chk("bp_sreq", 32'(sreq0), 1);
    chk("bp_smsg", 32'(smsg0), 32'(bp[0]));
    resp_en0 = 1'b1;
    wait_rx0(6);
    for (int i = 0; i < 6; i++)
      if (rx0.size() > i) chk("bp_order", 32'(rx0[i]), 32'(bp[i]));
    nwait(6);
    chk("bp_cnt_empty", 32'(cnt0), 0);

    // simultaneous push and pop at count 2, pointers wrapping
    nwait(8);
    resp_en0 = 1'b0;
    rx0.delete();
    send0(0, mk(0, 8));
    send0(1, mk(1, 9));
    send0(2, mk(2, 10));
    t = 0;
    while (cnt0 != 3'(2) && t < 40) begin nwait(1); t++; end
    chk("pp_cnt_reached", 32'(cnt0), 2);
    chk("pp_head_msg", 32'(smsg0), 32'(mk(2, 10)));
    sack0 = 1'b1;
    nwait(1);
    chk("pp_sreq_drop", 32'(sreq0), 0);
    sack0 = 1'b0;
    nwait(1);
    send0(3, mk(3, 11));
    @(posedge clk); #1;
    chk("pp_cnt_same", 32'(cnt0), 2);
    chk("pp_sreq", 32'(sreq0), 1);
    chk("pp_smsg", 32'(smsg0), 32'(mk(0, 8)));
    chk("pp_ack3", 32'(rack0[3]), 1);
    resp_en0 = 1'b1;
    wait_rx0(3);
    if (rx0.size() >= 3) begin
      chk("pp_rx0", 32'(rx0[0]), 32'(mk(0, 8)));
      chk("pp_rx1", 32'(rx0[1]), 32'(mk(1, 9)));
      chk("pp_rx2", 32'(rx0[2]), 32'(mk(3, 11)));
    end

    // fixed priority on dut1
    run1 = 1'b1;
    t = 0;
    while (rx1.size() < 12 && t < 600) begin nwait(1); t++; end
    chk("m1_rx_count", 32'(rx1.size()), 12);
    run1 = 1'b0;
    nx1 = 0; nx3 = 0;
    for (int i = 0; i < rx1.size(); i++) begin
      if (rx1[i][MSZ-1 -: 4] == 4'd1) begin chk("m1_ch1_seq", 32'(rx1[i][11:4]), 32'(nx1)); nx1++; end
      else begin chk("m1_ch3_seq", 32'(rx1[i][11:4]), 32'(nx3)); nx3++; end
    end
    chk("m1_ch3_served", 32'(n3 > 0), 1);

    // reset mid-handshake
    do_reset();
    hold0[0] = 1'b1;
    send0(0, mk(0, 20));
    send0(1, mk(1, 21));
    t = 0;
    while (!sreq0 && t < 40) begin nwait(1); t++; end
    chk("mr_sreq_up", 32'(sreq0), 1);
    chk("mr_ack0_up", 32'(rack0[0]), 1);
    rst = 1'b1;
    #1;
    chk("mr_ack_async", 32'(rack0), 0);
    chk("mr_sreq_async", 32'(sreq0), 0);
    chk("mr_ready_async", 32'(rdy0), 0);
    chk("mr_cnt_async", 32'(cnt0), 0);
    #1 rst = 1'b0;
    #1 chk("mr_ready_low", 32'(rdy0), 0);
    @(posedge clk); #1;
    chk("mr_ready_high", 32'(rdy0), 1);
    chk("mr_no_accept_yet", 32'(rack0[0]), 0);
    @(posedge clk); #1;
    chk("mr_reaccept", 32'(rack0[0]), 1);
    chk("mr_cnt", 32'(cnt0), 1);
    hold0[0] = 1'b0;
    rx0.delete();
    resp_en0 = 1'b1;
    wait_rx0(1);
    nwait(20);
    chk("mr_single_out", 32'(rx0.size()), 1);
    if (rx0.size() > 0) chk("mr_msg", 32'(rx0[0]), 32'(mk(0, 20)));
    chk("mr_cnt_end", 32'(cnt0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
